// File: rtl/sipo_bit_counter.sv
// Modulo-MODULUS bit counter for the SIPO receiver; pulses o_wrap for one cycle
// after the edge on which the count rolls over from MODULUS-1 to 0.
module sipo_bit_counter #(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned CNT_W   = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_wrap;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
      r_wrap  <= w_at_last;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_wrap;

endmodule

// File: rtl/sipo.sv
// Serial-in, parallel-out shift register with a word-boundary pulse; one bit is
// shifted in on every rising clock edge while reset is released.
module sipo #(
  parameter int unsigned      WIDTH       = 4,
  parameter bit               SHIFT_LEFT  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      CNT_W       = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_word_valid,
  output logic [CNT_W-1:0] o_bit_count
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;

  generate
    if (SHIFT_LEFT) begin : g_shl
      // First-received bit migrates toward the MSB.
      assign w_data_next = {r_data[WIDTH-2:0], i_serial_in};
    end else begin : g_shr
      assign w_data_next = {i_serial_in, r_data[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= RESET_VALUE;
    end else begin
      r_data <= w_data_next;
    end
  end

  sipo_bit_counter #(
    .MODULUS (WIDTH),
    .CNT_W   (CNT_W)
  ) u_bit_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_count (o_bit_count),
    .o_wrap  (o_word_valid)
  );

  assign o_data_out = r_data;

endmodule

// File: tb/tb_sipo.sv
// Directed bench for sipo: a WIDTH=4 left-shifting instance and a WIDTH=8
// right-shifting instance driven from a shared serial line with separate resets.
module tb_sipo;

  logic       clk;
  logic       rst_a_n;
  logic       rst_b_n;
  logic       serial_in;

  logic [3:0] a_data;
  logic       a_valid;
  logic [1:0] a_count;
  logic [7:0] b_data;
  logic       b_valid;
  logic [2:0] b_count;

  int n_cmp;
  int n_err;

  sipo #(
    .WIDTH       (4),
    .SHIFT_LEFT  (1'b1),
    .RESET_VALUE (4'b0000)
  ) u_dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_a_n),
    .i_serial_in  (serial_in),
    .o_data_out   (a_data),
    .o_word_valid (a_valid),
    .o_bit_count  (a_count)
  );

  sipo #(
    .WIDTH       (8),
    .SHIFT_LEFT  (1'b0),
    .RESET_VALUE (8'h00)
  ) u_dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_b_n),
    .i_serial_in  (serial_in),
    .o_data_out   (b_data),
    .o_word_valid (b_valid),
    .o_bit_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one serial bit, let one edge pass, then settle before sampling.
  task automatic step(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] d, input logic [1:0] c,
                         input logic v);
    check({tag, ".data"},  32'(a_data),  32'(d));
    check({tag, ".count"}, 32'(a_count), 32'(c));
    check({tag, ".valid"}, 32'(a_valid), 32'(v));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_a_n   = 1'b0;
    rst_b_n   = 1'b0;
    serial_in = 1'b1;

    // Reset held with serial_in=1: nothing shifts.
    @(posedge clk); @(posedge clk); #1;
    check_a("rst", 4'b0000, 2'd0, 1'b0);

    rst_a_n = 1'b1;
    step(1'b1); check_a("w1b1", 4'b0001, 2'd1, 1'b0);
    step(1'b1); check_a("w1b2", 4'b0011, 2'd2, 1'b0);
    step(1'b0); check_a("w1b3", 4'b0110, 2'd3, 1'b0);
    step(1'b0); check_a("w1b4", 4'b1100, 2'd0, 1'b1);

    step(1'b1); check_a("w2b1", 4'b1001, 2'd1, 1'b0);
    step(1'b1); check_a("w2b2", 4'b0011, 2'd2, 1'b0);
    step(1'b1); check_a("w2b3", 4'b0111, 2'd3, 1'b0);
    step(1'b1); check_a("w2b4", 4'b1111, 2'd0, 1'b1);

    // Two bits of a partial word, then an asynchronous reset mid-cycle.
    step(1'b1); check_a("p1", 4'b1111, 2'd1, 1'b0);
    step(1'b0); check_a("p2", 4'b1110, 2'd2, 1'b0);
    #2;
    rst_a_n = 1'b0;
    #1;
    check_a("async", 4'b0000, 2'd0, 1'b0);
    serial_in = 1'b1;
    @(posedge clk); #1;
    check_a("held", 4'b0000, 2'd0, 1'b0);
    rst_a_n = 1'b1;
    step(1'b1); check_a("r1", 4'b0001, 2'd1, 1'b0);
    step(1'b1); check_a("r2", 4'b0011, 2'd2, 1'b0);
    step(1'b1); check_a("r3", 4'b0111, 2'd3, 1'b0);
    step(1'b1); check_a("r4", 4'b1111, 2'd0, 1'b1);

    // Right-shifting 8-bit instance: first bit ends at bit 0.
    check("b.rst.data", 32'(b_data), 32'h00);
    rst_b_n = 1'b1;
    step(1'b1);
    check("b1.data",  32'(b_data),  32'h80);
    check("b1.count", 32'(b_count), 32'd1);
    step(1'b0);
    check("b2.data",  32'(b_data),  32'h40);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    check("b6.count", 32'(b_count), 32'd6);
    step(1'b1);
    check("b7.valid", 32'(b_valid), 32'd0);
    check("b7.count", 32'(b_count), 32'd7);
    step(1'b0);
    check("b8.data",  32'(b_data),  32'h4D);
    check("b8.count", 32'(b_count), 32'd0);
    check("b8.valid", 32'(b_valid), 32'd1);
    step(1'b0);
    check("b9.valid", 32'(b_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
